// File: rtl/vmx_pkg.sv
// Shared constants, FSM state encoding and tag helper for the PE chain sequencer.
package vmx_pkg;

    // Tag carried on non-weight beats; bit 7 clear so it never decodes as a load.
    localparam logic [7:0] TAG_IDLE     = 8'h7F;
    // Set on weight beats; the low 7 bits count down to 0 at the target PE.
    localparam logic [7:0] TAG_LOAD_BIT = 8'h80;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMPUTE,
        ST_DRAIN
    } state_t;

    // Head tag that makes a weight land in PE k (PE 0 is the head).
    function automatic logic [7:0] tag_for(input logic [6:0] k);
        return TAG_LOAD_BIT | {1'b0, k};
    endfunction

endpackage

// File: rtl/vmx_result_fifo.sv
// First-word-fall-through 32-bit result FIFO exposing its occupancy.
module vmx_result_fifo #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [31:0]       wr_data,
    input  logic              rd_en,
    output logic              rd_valid,
    output logic [31:0]       rd_data,
    output logic [CNT_W-1:0]  count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_rd;
    logic          full;

    assign rd_valid = (count != '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign do_rd    = rd_en && rd_valid;
    assign rd_data  = mem[rd_ptr];

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, do_rd})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Upstream credit accounting must never push into a full FIFO.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(wr_en && full));

endmodule

// File: rtl/vmx_pe_chain_sequencer.sv
// Sequencer for a linear chain of vector-matrix PEs: loads one weight per PE via
// the head tag, streams activations with zero partial sum, and collects the tail
// sums into a credit-protected result FIFO.
module vmx_pe_chain_sequencer #(
    parameter int N_PE      = 8,
    parameter int RES_DEPTH = 16,
    parameter int CNT_W     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        cfg_simd_mode,
    output logic        busy,
    output logic        done,
    input  logic        w_valid,
    output logic        w_ready,
    input  logic [15:0] w_data,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [15:0] a_data,
    input  logic        a_last,
    output logic        r_valid,
    input  logic        r_ready,
    output logic [31:0] r_data,
    output logic        pe_simd_mode,
    output logic [7:0]  pe_is_weight,
    output logic [15:0] pe_data,
    output logic [31:0] pe_sum_in,
    input  logic [31:0] pe_sum_out
);

    import vmx_pkg::*;

    localparam logic [6:0] LAST_WIDX = 7'(N_PE - 1);

    state_t           state_q;
    state_t           state_d;
    logic [6:0]       widx_q;
    logic [N_PE-1:0]  vld_sr;
    logic [CNT_W-1:0] inflight_q;
    logic [CNT_W-1:0] fifo_count;
    logic             w_hs;
    logic             a_hs;
    logic             start_acc;
    logic             capture;
    logic             credit_ok;

    assign w_hs      = w_valid && w_ready;
    assign a_hs      = a_valid && a_ready;
    assign start_acc = (state_q == ST_IDLE) && start;
    assign capture   = vld_sr[N_PE-1];
    // Every issued beat already owns a FIFO slot, so the FIFO can never overflow.
    assign credit_ok = (fifo_count + inflight_q) < CNT_W'(RES_DEPTH);
    assign pe_sum_in = '0;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start)                       state_d = ST_LOAD;
            ST_LOAD:    if (w_hs && widx_q == LAST_WIDX) state_d = ST_COMPUTE;
            ST_COMPUTE: if (a_hs && a_last)              state_d = ST_DRAIN;
            ST_DRAIN:   if (inflight_q == '0)            state_d = ST_IDLE;
            default:                                     state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: stream readiness, busy, and the completion pulse.
    always_comb begin
        w_ready = 1'b0;
        a_ready = 1'b0;
        done    = 1'b0;
        busy    = (state_q != ST_IDLE);
        case (state_q)
            ST_LOAD:    w_ready = 1'b1;
            ST_COMPUTE: a_ready = credit_ok;
            ST_DRAIN:   done    = (inflight_q == '0);
            default:    ;
        endcase
    end

    // Weight index and job-wide simd mode, both captured on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            widx_q       <= '0;
            pe_simd_mode <= 1'b0;
        end else if (start_acc) begin
            widx_q       <= '0;
            pe_simd_mode <= cfg_simd_mode;
        end else if (w_hs) begin
            widx_q       <= widx_q + 7'd1;
        end
    end

    // Chain-head registers: one cycle of weight, activation, or idle bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_is_weight <= TAG_IDLE;
            pe_data      <= '0;
        end else if (w_hs) begin
            pe_is_weight <= tag_for(widx_q);
            pe_data      <= w_data;
        end else if (a_hs) begin
            pe_is_weight <= TAG_IDLE;
            pe_data      <= a_data;
        end else begin
            pe_is_weight <= TAG_IDLE;
            pe_data      <= '0;
        end
    end

    // Valid shift register mirrors activation beats walking down the chain.
    generate
        if (N_PE == 1) begin : g_sr1
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_sr <= '0;
                end else begin
                    vld_sr <= a_hs;
                end
            end
        end else begin : g_srn
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_sr <= '0;
                end else begin
                    vld_sr <= {vld_sr[N_PE-2:0], a_hs};
                end
            end
        end
    endgenerate

    // In-flight count tracks the ones held in the valid shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= '0;
        end else begin
            case ({a_hs, capture})
                2'b10:   inflight_q <= inflight_q + CNT_W'(1);
                2'b01:   inflight_q <= inflight_q - CNT_W'(1);
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    vmx_result_fifo #(
        .DEPTH (RES_DEPTH),
        .CNT_W (CNT_W)
    ) u_res_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (capture),
        .wr_data  (pe_sum_out),
        .rd_en    (r_ready),
        .rd_valid (r_valid),
        .rd_data  (r_data),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_vmx_pe_chain_sequencer.sv
// Directed bench for vmx_pe_chain_sequencer with a 4-PE behavioural chain model.
module tb_vmx_pe_chain_sequencer;

    localparam int N  = 4;
    localparam int RD = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        cfg_simd_mode = 1'b0;
    logic        busy;
    logic        done;
    logic        w_valid = 1'b0;
    logic        w_ready;
    logic [15:0] w_data = '0;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [15:0] a_data = '0;
    logic        a_last = 1'b0;
    logic        r_valid;
    logic        r_ready = 1'b0;
    logic [31:0] r_data;
    logic        pe_simd_mode;
    logic [7:0]  pe_is_weight;
    logic [15:0] pe_data;
    logic [31:0] pe_sum_in;
    logic [31:0] pe_sum_out;

    always #5 clk = ~clk;

    vmx_pe_chain_sequencer #(.N_PE(N), .RES_DEPTH(RD), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_simd_mode(cfg_simd_mode),
        .busy(busy), .done(done),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_last(a_last),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
        .pe_simd_mode(pe_simd_mode), .pe_is_weight(pe_is_weight), .pe_data(pe_data),
        .pe_sum_in(pe_sum_in), .pe_sum_out(pe_sum_out)
    );

    // PE chain model: each PE sees its inputs combinationally, sum_out = sum_in + w*data,
    // and a register stage sits between neighbouring PEs. A PE loads when its tag is 8'h80.
    logic [15:0] pw     [N];
    logic [7:0]  tag_r  [N-1];
    logic [15:0] dat_r  [N-1];
    logic [31:0] sum_r  [N-1];
    logic [7:0]  in_tag [N];
    logic [15:0] in_dat [N];
    logic [31:0] in_sum [N];
    logic [31:0] out_sum[N];

    always_comb begin
        in_tag[0] = pe_is_weight;
        in_dat[0] = pe_data;
        in_sum[0] = pe_sum_in;
        for (int k = 1; k < N; k++) begin
            in_tag[k] = tag_r[k-1];
            in_dat[k] = dat_r[k-1];
            in_sum[k] = sum_r[k-1];
        end
        for (int k = 0; k < N; k++) begin
            out_sum[k] = in_sum[k] + 32'(pw[k]) * 32'(in_dat[k]);
        end
    end

    assign pe_sum_out = out_sum[N-1];

    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (in_tag[k][7] && in_tag[k][6:0] == 7'd0) pw[k] <= in_dat[k];
        end
        for (int k = 0; k < N - 1; k++) begin
            tag_r[k] <= {in_tag[k][7], in_tag[k][6:0] - 7'd1};
            dat_r[k] <= in_dat[k];
            sum_r[k] <= out_sum[k];
        end
    end

    // Event monitors: edge index of every handshake, pop and done pulse.
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          hs_cyc[$];
    int          pop_cyc[$];
    logic [31:0] got[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (a_valid && a_ready) hs_cyc.push_back(cyc);
        if (r_valid && r_ready) begin
            got.push_back(r_data);
            pop_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
    endtask

    // All drive tasks are entered and left at a falling edge.
    task automatic do_start(input logic simd);
        start = 1'b1;
        cfg_simd_mode = simd;
        @(negedge clk);
        start = 1'b0;
        cfg_simd_mode = 1'b0;
    endtask

    task automatic load_weights(input logic [63:0] ws, input bit check_tags);
        for (int i = 0; i < N; i++) begin
            w_valid = 1'b1;
            w_data  = ws[16*i +: 16];
            @(posedge clk);
            #1;
            if (check_tags) begin
                chk($sformatf("head_tag_w%0d", i), 32'(pe_is_weight), 32'h80 + i);
                chk($sformatf("head_data_w%0d", i), 32'(pe_data), 32'(ws[16*i +: 16]));
            end
            @(negedge clk);
        end
        w_valid = 1'b0;
    endtask

    task automatic stream(input int n, input int base, input int step, input bit sparse,
                          input int budget, output int acc);
        int k;
        k = 0;
        acc = 0;
        while (acc < n && k < budget) begin
            a_valid = sparse ? ((k / 3) % 2 == 0) : 1'b1;
            a_data  = 16'(base + acc * step);
            a_last  = (acc == n - 1);
            if (a_valid && a_ready) acc++;
            k++;
            @(negedge clk);
        end
        a_valid = 1'b0;
        a_last  = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int k;
        k = 0;
        while (done_cnt == d0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("done_pulse_count", done_cnt, d0 + 1);
    endtask

    typedef struct {
        logic [63:0] ws;
        int          base;
        int          step;
        int          n;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc, acc2, d0, g0, h0;

        tbl[0] = '{ws: 64'h0004_0003_0002_0001, base: 5,     step: 2, n: 2, exp0: 32'd50,       exp1: 32'd70};
        tbl[1] = '{ws: 64'h0001_0001_0001_0001, base: 9,     step: 0, n: 1, exp0: 32'd36,       exp1: 32'd0};
        tbl[2] = '{ws: 64'h0002_0002_0002_0002, base: 3,     step: 0, n: 1, exp0: 32'd24,       exp1: 32'd0};
        tbl[3] = '{ws: 64'h0007_0000_0000_0000, base: 100,   step: 1, n: 2, exp0: 32'd700,      exp1: 32'd707};
        tbl[4] = '{ws: 64'h0000_0000_0001_FFFF, base: 65535, step: 0, n: 1, exp0: 32'hFFFF0000, exp1: 32'd0};
        tbl[5] = '{ws: 64'h0028_001E_0014_000A, base: 0,     step: 1, n: 2, exp0: 32'd0,        exp1: 32'd100};

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_w_ready", w_ready, 0);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_r_valid", r_valid, 0);
        chk("rst_simd", pe_simd_mode, 0);
        chk("rst_tag", pe_is_weight, 8'h7F);
        chk("rst_data", pe_data, 0);
        chk("rst_sum_in", pe_sum_in, 0);
        rst_n = 1'b1;
        r_ready = 1'b1;
        @(negedge clk);

        // Table of single jobs, each with activations straight after the last weight.
        for (int r = 0; r < 6; r++) begin
            d0 = done_cnt;
            g0 = got.size();
            h0 = hs_cyc.size();
            do_start(1'b0);
            if (r == 0) chk("busy_after_start", busy, 1);
            load_weights(tbl[r].ws, r == 0);
            stream(tbl[r].n, tbl[r].base, tbl[r].step, 1'b0, 50, acc);
            wait_done(d0, 60);
            repeat (2) @(negedge clk);
            chk($sformatf("row%0d_count", r), got.size() - g0, tbl[r].n);
            for (int j = 0; j < tbl[r].n; j++) begin
                if (got.size() > g0 + j && hs_cyc.size() > h0 + j) begin
                    chk($sformatf("row%0d_rdata%0d", r, j), got[g0+j], (j == 0) ? tbl[r].exp0 : tbl[r].exp1);
                    chk($sformatf("row%0d_latency%0d", r, j), pop_cyc[g0+j] - hs_cyc[h0+j], N + 1);
                end
            end
            if (hs_cyc.size() >= h0 + tbl[r].n)
                chk($sformatf("row%0d_done_timing", r), done_cyc, hs_cyc[h0+tbl[r].n-1] + N + 1);
            chk($sformatf("row%0d_busy_after", r), busy, 0);
            chk($sformatf("row%0d_idle_tag", r), pe_is_weight, 8'h7F);
        end

        // Backpressure: with r_ready low only RES_DEPTH activations are admitted.
        r_ready = 1'b0;
        d0 = done_cnt;
        g0 = got.size();
        do_start(1'b0);
        load_weights(64'h0000_0000_0000_0001, 1'b0);
        stream(20, 1, 1, 1'b0, 40, acc);
        chk("bp_accepted", acc, RD);
        chk("bp_a_ready_low", a_ready, 0);
        chk("bp_r_valid", r_valid, 1);
        r_ready = 1'b1;
        stream(12, 9, 1, 1'b0, 200, acc2);
        chk("bp_accepted_rest", acc2, 12);
        wait_done(d0, 60);
        repeat (3) @(negedge clk);
        chk("bp_count", got.size() - g0, 20);
        for (int i = 0; i < 20; i++) begin
            if (got.size() > g0 + i) chk($sformatf("bp_order%0d", i), got[g0+i], i + 1);
        end

        // Sparse activations: order, count and fixed latency.
        d0 = done_cnt;
        g0 = got.size();
        h0 = hs_cyc.size();
        do_start(1'b0);
        load_weights(64'h0001_0001_0001_0001, 1'b0);
        stream(6, 100, 1, 1'b1, 60, acc);
        wait_done(d0, 60);
        repeat (2) @(negedge clk);
        chk("sparse_count", got.size() - g0, 6);
        for (int i = 0; i < 6; i++) begin
            if (got.size() > g0 + i && hs_cyc.size() > h0 + i) begin
                chk($sformatf("sparse_rdata%0d", i), got[g0+i], 4 * (100 + i));
                chk($sformatf("sparse_latency%0d", i), pop_cyc[g0+i] - hs_cyc[h0+i], N + 1);
            end
        end

        // Start while busy is ignored; weight index and mode are untouched.
        d0 = done_cnt;
        g0 = got.size();
        do_start(1'b0);
        w_valid = 1'b1;
        w_data = 16'd1;
        @(posedge clk);
        @(negedge clk);
        w_data = 16'd2;
        start = 1'b1;
        cfg_simd_mode = 1'b1;
        @(posedge clk);
        #1;
        chk("busy_start_tag", pe_is_weight, 8'h81);
        chk("busy_start_simd", pe_simd_mode, 0);
        chk("busy_start_busy", busy, 1);
        @(negedge clk);
        start = 1'b0;
        cfg_simd_mode = 1'b0;
        w_data = 16'd3;
        @(posedge clk);
        @(negedge clk);
        w_data = 16'd4;
        @(posedge clk);
        @(negedge clk);
        w_valid = 1'b0;
        stream(1, 2, 0, 1'b0, 50, acc);
        wait_done(d0, 60);
        repeat (2) @(negedge clk);
        chk("busy_start_count", got.size() - g0, 1);
        if (got.size() > g0) chk("busy_start_rdata", got[g0], 20);

        // New job with simd=1 holds the mode throughout.
        d0 = done_cnt;
        g0 = got.size();
        do_start(1'b1);
        chk("simd_at_load", pe_simd_mode, 1);
        load_weights(64'h0001_0001_0001_0001, 1'b0);
        chk("simd_at_compute", pe_simd_mode, 1);
        stream(1, 6, 0, 1'b0, 50, acc);
        chk("simd_at_drain", pe_simd_mode, 1);
        wait_done(d0, 60);
        chk("simd_after_done", pe_simd_mode, 1);
        repeat (2) @(negedge clk);
        if (got.size() > g0) chk("simd_rdata", got[g0], 24);

        // Results persist after done; a new start is allowed while they wait.
        r_ready = 1'b0;
        d0 = done_cnt;
        do_start(1'b0);
        load_weights(64'h0001_0001_0001_0001, 1'b0);
        stream(1, 5, 0, 1'b0, 50, acc);
        wait_done(d0, 60);
        repeat (2) @(negedge clk);
        chk("persist_r_valid", r_valid, 1);
        chk("persist_r_data", r_data, 20);
        chk("persist_busy", busy, 0);

        // Reset in the middle of LOAD abandons the job.
        do_start(1'b0);
        w_valid = 1'b1;
        w_data = 16'h00AA;
        @(posedge clk);
        @(negedge clk);
        w_data = 16'h00BB;
        @(posedge clk);
        @(negedge clk);
        w_valid = 1'b0;
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("midrst_tag", pe_is_weight, 8'h7F);
        chk("midrst_busy", busy, 0);
        chk("midrst_r_valid", r_valid, 0);
        chk("midrst_w_ready", w_ready, 0);
        chk("midrst_data", pe_data, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_no_done", done_cnt, d0);
        chk("midrst_busy_after", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
